ready_valid_sink_checker: RTL

Synthesizable receiver end of the ready/valid protocol used by the half-buffer pipeline library. It consumes a stream and applies a programmable backpressure pattern on `in_ready` (always-ready, busy, pseudo-random). It checks each accepted beat against an expected incrementing sequence and reports transfer, stall and error counts. It sits at a pipeline's output port, either in silicon self-test or as a hardware stand-in for a bench receiver driver.

---
 rtl/ready_valid_sink_checker.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/ready_valid_sink_checker.sv
// ready_valid_sink_checker
//
// Receiver end of a ready/valid stream. It applies a programmable
// backpressure pattern on in_ready and checks every accepted beat against an
// incrementing sequence that starts at first_data. It reports the number of
// accepted beats, data errors and stall cycles, and captures the first error.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   start          single-cycle pulse that arms a run (ignored while busy)
//   mode           backpressure mode, sampled on start:
//                  0 always ready, 1 busy (1 of 4), 2 random (LFSR), 3 as 0
//   first_data     expected payload of beat 0, sampled on start
//   in_valid       upstream valid
//   in_data        upstream payload
//   in_ready       backpressure to upstream (registered state only)
//   busy           high while a run is in progress
//   done           high once NUM_SEQUENCE beats have been accepted
//   mismatch       sticky, set on the first data error of a run
//   rx_count       accepted beats
//   err_count      mismatching beats, saturating
//   stall_count    RUN cycles with in_valid=1 and in_ready=0, saturating
//   first_err_idx  rx_count value of the first mismatching beat
//   first_err_data payload of the first mismatching beat
module ready_valid_sink_checker #(
  parameter int             DATA_WIDTH   = 8,
  parameter int             NUM_SEQUENCE = 16,
  parameter int             CNT_WIDTH    = 16,
  parameter logic [7:0]     LFSR_SEED    = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] first_data,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  mismatch,
  output logic [CNT_WIDTH-1:0]  rx_count,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [CNT_WIDTH-1:0]  stall_count,
  output logic [CNT_WIDTH-1:0]  first_err_idx,
  output logic [DATA_WIDTH-1:0] first_err_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    M_ALWAYS = 2'd0,
    M_BUSY   = 2'd1,
    M_RANDOM = 2'd2,
    M_RSVD   = 2'd3
  } bp_mode_t;

  localparam logic [CNT_WIDTH-1:0] LP_NUM_SEQ = CNT_WIDTH'(NUM_SEQUENCE);

  state_t                  r_state;
  state_t                  w_state_next;
  bp_mode_t                r_mode;
  logic [DATA_WIDTH-1:0]   r_expected;
  logic [CNT_WIDTH-1:0]    r_rx_count;
  logic [CNT_WIDTH-1:0]    r_err_count;
  logic [CNT_WIDTH-1:0]    r_stall_count;
  logic [CNT_WIDTH-1:0]    r_first_err_idx;
  logic [DATA_WIDTH-1:0]   r_first_err_data;
  logic                    r_mismatch;
  logic [1:0]              r_phase;
  logic [7:0]              r_lfsr;

  logic                    w_run;
  logic                    w_pattern;
  logic                    w_ready;
  logic                    w_xfer;
  logic                    w_start_ok;
  logic [CNT_WIDTH-1:0]    w_rx_next;
  logic                    w_last;
  logic                    w_lfsr_fb;

  assign w_run      = (r_state == S_RUN);
  assign w_start_ok = start && (r_state != S_RUN);
  assign w_rx_next  = r_rx_count + 1'b1;
  // Taps x^8+x^6+x^5+x^4+1 on a left-shifting Fibonacci register.
  assign w_lfsr_fb  = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  // Ready pattern is decoded from registers only, so in_ready never has a
  // combinational path from in_valid or in_data.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_pattern = 1'b1;
    unique case (r_mode)
      M_BUSY:   w_pattern = (r_phase == 2'd3);
      M_RANDOM: w_pattern = r_lfsr[0];
      default:  w_pattern = 1'b1;
    endcase
  end

  assign w_ready = w_run && w_pattern;
  assign w_xfer  = in_valid && w_ready;
  assign w_last  = w_xfer && (w_rx_next == LP_NUM_SEQ);

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs as they were before the edge.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start)  w_state_next = S_RUN;
      S_RUN:   if (w_last) w_state_next = S_DONE;
      S_DONE:  if (start)  w_state_next = S_RUN;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Pattern generators, expected value, counters and first-error capture
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode           <= M_ALWAYS;
      r_expected       <= '0;
      r_rx_count       <= '0;
      r_err_count      <= '0;
      r_stall_count    <= '0;
      r_first_err_idx  <= '0;
      r_first_err_data <= '0;
      r_mismatch       <= 1'b0;
      r_phase          <= 2'd0;
      r_lfsr           <= LFSR_SEED;
    end else if (w_start_ok) begin
      r_mode           <= bp_mode_t'(mode);
      r_expected       <= first_data;
      r_rx_count       <= '0;
      r_err_count      <= '0;
      r_stall_count    <= '0;
      r_first_err_idx  <= '0;
      r_first_err_data <= '0;
      r_mismatch       <= 1'b0;
      r_phase          <= 2'd0;
      r_lfsr           <= LFSR_SEED;
    end else if (w_run) begin
      // Both pattern sources advance every RUN cycle, transfer or not.
      r_phase <= r_phase + 2'd1;
      r_lfsr  <= {r_lfsr[6:0], w_lfsr_fb};

      if (w_xfer) begin
        r_rx_count <= w_rx_next;
        r_expected <= r_expected + 1'b1;
        if (in_data != r_expected) begin
          if (r_err_count != '1) r_err_count <= r_err_count + 1'b1;
          // Capture index uses the pre-increment count.
          if (!r_mismatch) begin
            r_first_err_idx  <= r_rx_count;
            r_first_err_data <= in_data;
            r_mismatch       <= 1'b1;
          end
        end
      end

      if (in_valid && !w_ready && (r_stall_count != '1))
        r_stall_count <= r_stall_count + 1'b1;
    end
  end

  assign in_ready       = w_ready;
  assign busy           = w_run;
  assign done           = (r_state == S_DONE);
  assign mismatch       = r_mismatch;
  assign rx_count       = r_rx_count;
  assign err_count      = r_err_count;
  assign stall_count    = r_stall_count;
  assign first_err_idx  = r_first_err_idx;
  assign first_err_data = r_first_err_data;

endmodule
